clk_period_meter: RTL and testbench



---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/clk_period_meter_if.sv | 21 ++
 rtl/clk_period_meter_sync_edge_det.sv | 45 ++++
 rtl/clk_period_meter.sv | 119 +++++++++++
 tb/tb_clk_period_meter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meas_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } meas_state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement bundle: the signal under test going in, the measured results coming out.
interface clk_period_meter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] high_time;
    logic                 valid;
    logic                 stalled;
    logic                 level;

    modport master (
        input  sig_in,
        output period, high_time, valid, stalled, level
    );

    modport slave (
        output sig_in,
        input  period, high_time, valid, stalled, level
    );
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Synchronizer chain for an asynchronous input plus registered rise/fall detection.
module sync_edge_det
    import clk_meas_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic primed
);
    localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N-1:0] sync_reg;
    logic [N:0]   fill_reg;
    logic         prev_reg;
    logic         rise_reg;
    logic         fall_reg;

    // fill_reg marks when level reflects sig_in rather than the reset value of the chain.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_reg <= '0;
            fill_reg <= '0;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[N-2:0], sig_in};
            fill_reg <= {fill_reg[N-1:0], 1'b1};
            prev_reg <= sync_reg[N-1];
            rise_reg <= sync_reg[N-1] & ~prev_reg;
            fall_reg <= ~sync_reg[N-1] & prev_reg;
        end
    end

    assign level  = sync_reg[N-1];
    assign rise   = rise_reg;
    assign fall   = fall_reg;
    assign primed = fill_reg[N];

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles,
// reporting one measurement per input period.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int                   CNT_WIDTH   = 32,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT     = {CNT_WIDTH{1'b1}}
) (
    input  logic              clk_in,
    input  logic              rst,
    clk_period_meter_if.master meas
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    meas_state_e          state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_p_reg, cnt_h_reg, high_hold_reg;
    logic [CNT_WIDTH-1:0] period_reg, high_time_reg;
    logic                 valid_reg, stalled_reg;
    logic                 level, rise, fall, primed, timeout;
    logic                 load_cnt, inc_p, inc_h, latch_high, commit, set_stall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (meas.sig_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .primed (primed)
    );

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    assign timeout = (cnt_p_reg >= TIMEOUT);

    always_ff @(posedge clk_in) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (primed && !level) state_next = ARM;
            ARM:     if (rise)             state_next = HIGH;
            HIGH:    if (fall)             state_next = LOW;
                     else if (timeout)     state_next = IDLE;
            LOW:     if (rise)             state_next = HIGH;
                     else if (timeout)     state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // An edge always beats a simultaneous timeout.
    always_comb begin
        load_cnt   = 1'b0;
        inc_p      = 1'b0;
        inc_h      = 1'b0;
        latch_high = 1'b0;
        commit     = 1'b0;
        set_stall  = 1'b0;
        case (state_reg)
            ARM:  load_cnt = rise;
            HIGH: begin
                inc_p      = 1'b1;
                inc_h      = 1'b1;
                latch_high = fall;
                set_stall  = !fall && timeout;
            end
            LOW: begin
                commit    = rise;
                load_cnt  = rise;
                inc_p     = !rise;
                set_stall = !rise && timeout;
            end
            default: ;
        endcase
    end

    // high_time is held in a shadow until the period completes so both update together.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_p_reg     <= '0;
            cnt_h_reg     <= '0;
            high_hold_reg <= '0;
            period_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            stalled_reg   <= 1'b0;
        end else begin
            valid_reg <= commit;
            if (load_cnt) begin
                cnt_p_reg <= CNT_ONE;
                cnt_h_reg <= CNT_ONE;
            end else begin
                if (inc_p) cnt_p_reg <= sat_inc(cnt_p_reg);
                if (inc_h) cnt_h_reg <= sat_inc(cnt_h_reg);
            end
            if (latch_high) high_hold_reg <= cnt_h_reg;
            if (commit) begin
                period_reg    <= cnt_p_reg;
                high_time_reg <= high_hold_reg;
                stalled_reg   <= 1'b0;
            end else if (set_stall) begin
                stalled_reg <= 1'b1;
            end
        end
    end

    assign meas.period    = period_reg;
    assign meas.high_time = high_time_reg;
    assign meas.valid     = valid_reg;
    assign meas.stalled   = stalled_reg;
    assign meas.level     = level;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed and random pulse trains checked against a rise/fall timeline model.
module tb_clk_period_meter;
    localparam int CW   = 16;
    localparam int SYNC = 2;
    localparam int TO   = 20;
    localparam int LAT  = SYNC + 2;

    typedef struct {
        int cyc;
        int period;
        int high;
        int stalled;
    } meas_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    meas_t obs_q[$];
    meas_t exp_q[$];
    int    stall_cyc[$];
    logic  stalled_d = 1'b0;

    bit armed = 0;
    int prev_hi = 0;
    int prev_lo = 0;

    clk_period_meter_if #(.CNT_WIDTH(CW)) meas ();

    clk_period_meter #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (16'd20)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .meas   (meas)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (meas.valid)
            obs_q.push_back('{cyc, int'(meas.period), int'(meas.high_time), int'(meas.stalled)});
        if (meas.stalled && !stalled_d) stall_cyc.push_back(cyc);
        stalled_d = meas.stalled;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int o, input int e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic hold(input logic v, input int n);
        meas.sig_in = v;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Each rise closes the previous pulse: period = hi + lo, high = hi.
    task automatic pulse(input int hi, input int lo);
        if (armed) exp_q.push_back('{cyc + LAT, prev_hi + prev_lo, prev_hi, 0});
        armed   = 1;
        prev_hi = hi;
        prev_lo = lo;
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic do_reset(input logic sig_level);
        meas.sig_in = sig_level;
        rst = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst   = 1'b0;
        armed = 0;
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, ".count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].cyc", tag, i),     obs_q[i].cyc,     exp_q[i].cyc);
            check($sformatf("%s[%0d].period", tag, i), obs_q[i].period,  exp_q[i].period);
            check($sformatf("%s[%0d].high", tag, i),    obs_q[i].high,    exp_q[i].high);
            check($sformatf("%s[%0d].stall", tag, i),   obs_q[i].stalled, exp_q[i].stalled);
        end
        $display("%s: %0d measurements observed, %0d expected", tag, obs_q.size(), exp_q.size());
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int last_exp;
        meas.sig_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset.period",  int'(meas.period),    0);
        check("reset.high",    int'(meas.high_time), 0);
        check("reset.valid",   int'(meas.valid),     0);
        check("reset.stalled", int'(meas.stalled),   0);
        check("reset.level",   int'(meas.level),     0);
        rst = 1'b0;

        // Divide-by-4, 50% duty
        do_reset(1'b0); hold(1'b0, 4);
        repeat (6) pulse(2, 2);
        hold(1'b0, LAT + 1); compare("div4");

        // Divide-by-10, 30% duty
        do_reset(1'b0); hold(1'b0, 4);
        repeat (5) pulse(3, 7);
        hold(1'b0, LAT + 1); compare("div10");

        // Minimum period
        do_reset(1'b0); hold(1'b0, 4);
        repeat (8) pulse(1, 1);
        hold(1'b0, LAT + 1); compare("div2");

        // Random pulse trains
        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0); hold(1'b0, 4);
            for (int k = 0; k < 6; k++) pulse($urandom_range(1, 8), $urandom_range(1, 8));
            hold(1'b0, LAT + 1); compare($sformatf("rand%0d", r));
        end

        // Input high through reset release
        do_reset(1'b1);
        hold(1'b1, 10);
        hold(1'b0, 4);
        repeat (4) pulse(4, 4);
        hold(1'b0, LAT + 1); compare("high_at_reset");

        // Reset in the middle of a HIGH phase
        do_reset(1'b0); hold(1'b0, 4);
        repeat (3) pulse(3, 3);
        exp_q.push_back('{cyc + LAT, prev_hi + prev_lo, prev_hi, 0});
        hold(1'b1, 6);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check("midrst.period",  int'(meas.period),    0);
        check("midrst.high",    int'(meas.high_time), 0);
        check("midrst.valid",   int'(meas.valid),     0);
        check("midrst.stalled", int'(meas.stalled),   0);
        check("midrst.level",   int'(meas.level),     0);
        rst   = 1'b0;
        armed = 0;
        hold(1'b1, 3);
        hold(1'b0, 4);
        repeat (3) pulse(5, 2);
        hold(1'b0, LAT + 1); compare("mid_reset");

        // Period exactly at TIMEOUT, then period 6, then stop low
        do_reset(1'b0); hold(1'b0, 4);
        stall_cyc.delete();
        repeat (3) pulse(5, 15);
        repeat (4) pulse(3, 3);
        last_exp = exp_q[exp_q.size()-1].cyc;
        hold(1'b0, 30);
        compare("timeout_run");
        check("stall.events", stall_cyc.size(), 1);
        if (stall_cyc.size() > 0) check("stall.cyc", stall_cyc[0], last_exp + TO);
        check("stall.flag",   int'(meas.stalled),   1);
        check("stall.period", int'(meas.period),    6);
        check("stall.high",   int'(meas.high_time), 3);

        // Restart: first rise only arms, the second clears stalled with a valid
        armed = 0;
        pulse(3, 3);
        check("restart.stalled_kept", int'(meas.stalled), 1);
        pulse(3, 3);
        hold(1'b0, LAT + 1);
        compare("restart");
        check("restart.stalled", int'(meas.stalled), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
